// File: rtl/mic1_mem_ctrl.sv
// MIC-1 memory interface: turns datapath read/write/fetch requests into handshaked
// data-port and instruction-port transactions. Optional ack timeout via MEM_TIMEOUT_EN.
module mic1_mem_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  input  logic [31:0]       MAR,
  input  logic [31:0]       MDR,
  input  logic [31:0]       PC,
  output logic [31:0]       RAM_data,
  output logic [31:0]       ROM_data,
  output logic              mdr_load,
  output logic              mbr_load,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_dState, r_fState;
  logic                r_memReq, r_memWe, r_isRead, r_mdrLoad, r_errData;
  logic [ADDR_W-1:0]   r_memAddr;
  logic [31:0]         r_memWdata, r_ramData;
  logic                r_imemReq, r_mbrLoad, r_errFetch;
  logic [ADDR_W-1:0]   r_imemAddr;
  logic [31:0]         r_romData;
  logic                w_dataReq, w_stall;
  logic                w_unusedMar;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_dCnt, r_fCnt;
`endif

  assign w_dataReq   = rd_req | wr_req;
  assign w_stall     = (w_dataReq & (r_dState != S_IDLE)) | (fetch_req & (r_fState != S_IDLE));
  assign w_unusedMar = &{1'b0, MAR[31:ADDR_W-2]};

  // Data FSM; a simultaneous read and write keeps only the write and flags an error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dState   <= S_IDLE;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_isRead   <= 1'b0;
      r_mdrLoad  <= 1'b0;
      r_errData  <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_ramData  <= '0;
`ifdef MEM_TIMEOUT_EN
      r_dCnt     <= '0;
`endif
    end else begin
      case (r_dState)
        S_IDLE: begin
          r_mdrLoad <= 1'b0;
          if (w_dataReq && !w_stall) begin
            r_memAddr  <= {MAR[ADDR_W-3:0], 2'b00};
            r_memWdata <= MDR;
            r_memWe    <= wr_req;
            r_isRead   <= rd_req & ~wr_req;
            r_memReq   <= 1'b1;
            r_dState   <= S_BUSY;
            if (rd_req && wr_req) r_errData <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            r_dCnt     <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            r_memReq <= 1'b0;
            r_dState <= S_DONE;
            if (r_isRead) begin
              r_ramData <= mem_rdata;
              r_mdrLoad <= 1'b1;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_dCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_memReq  <= 1'b0;
            r_dState  <= S_DONE;
            r_errData <= 1'b1;
            if (r_isRead) begin
              r_ramData <= 32'hDEADBEEF;
              r_mdrLoad <= 1'b1;
            end
          end else begin
            r_dCnt <= r_dCnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_mdrLoad <= 1'b0;
          r_dState  <= S_IDLE;
        end
        default: r_dState <= S_IDLE;
      endcase
    end
  end

  // Fetch FSM runs independently of the data FSM on the byte-wide instruction port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fState   <= S_IDLE;
      r_imemReq  <= 1'b0;
      r_imemAddr <= '0;
      r_mbrLoad  <= 1'b0;
      r_romData  <= '0;
      r_errFetch <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_fCnt     <= '0;
`endif
    end else begin
      case (r_fState)
        S_IDLE: begin
          r_mbrLoad <= 1'b0;
          if (fetch_req && !w_stall) begin
            r_imemAddr <= PC[ADDR_W-1:0];
            r_imemReq  <= 1'b1;
            r_fState   <= S_BUSY;
`ifdef MEM_TIMEOUT_EN
            r_fCnt     <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (imem_ack) begin
            r_imemReq <= 1'b0;
            r_romData <= {24'b0, imem_rdata};
            r_mbrLoad <= 1'b1;
            r_fState  <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          else if (r_fCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_imemReq  <= 1'b0;
            r_romData  <= 32'h000000FF;
            r_mbrLoad  <= 1'b1;
            r_errFetch <= 1'b1;
            r_fState   <= S_DONE;
          end else begin
            r_fCnt <= r_fCnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_mbrLoad <= 1'b0;
          r_fState  <= S_IDLE;
        end
        default: r_fState <= S_IDLE;
      endcase
    end
  end

  assign RAM_data  = r_ramData;
  assign ROM_data  = r_romData;
  assign mdr_load  = r_mdrLoad;
  assign mbr_load  = r_mbrLoad;
  assign stall     = w_stall;
  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign imem_req  = r_imemReq;
  assign imem_addr = r_imemAddr;
  assign err       = r_errData | r_errFetch;

endmodule

// File: doc/mic1_mem_ctrl.md
Name: mic1_mem_ctrl

Overview:
- Memory interface stage directly upstream of the MIC-1 datapath.
- Converts datapath read, write and fetch requests into handshaked transactions on a word-wide data memory port and a byte-wide instruction memory port.
- Returns RAM_data and ROM_data to the datapath, with single-cycle load strobes for MDR and MBR.
- Asserts stall while a new request collides with an outstanding transaction.

Parameters:
- ADDR_W, 32, width of mem_addr and imem_addr.
- TIMEOUT_CYCLES, 16, ack wait limit; used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous active-low reset.
- rd_req  in  1  datapath read request (MIR read bit).
- wr_req  in  1  datapath write request (MIR write bit).
- fetch_req  in  1  datapath fetch request (MIR fetch bit).
- MAR  in  32  word address for data access.
- MDR  in  32  write data.
- PC  in  32  byte address for fetch.
- RAM_data  out  32  registered read data to MDR.
- ROM_data  out  32  registered fetched byte, zero-extended (bits 31:8 = 0).
- mdr_load  out  1  one-cycle pulse: RAM_data valid this cycle.
- mbr_load  out  1  one-cycle pulse: ROM_data valid this cycle.
- stall  out  1  datapath must hold its current microinstruction.
- mem_req  out  1  data port request, held until mem_ack.
- mem_we  out  1  data port write enable, valid with mem_req.
- mem_addr  out  ADDR_W  byte address, {MAR[ADDR_W-3:0],2'b00}.
- mem_wdata  out  32  write data captured from MDR.
- mem_ack  in  1  data port completion.
- mem_rdata  in  32  data port read data, valid with mem_ack.
- imem_req  out  1  instruction port request, held until imem_ack.
- imem_addr  out  ADDR_W  PC[ADDR_W-1:0].
- imem_ack  in  1  instruction port completion.
- imem_rdata  in  8  fetched byte, valid with imem_ack.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous) forces every output to 0; both FSMs go to IDLE.
- Data FSM states:
  - IDLE: on rd_req or wr_req, capture mem_addr, mem_wdata and mem_we (1 for wr_req), then go to BUSY.
  - BUSY: mem_req=1. On mem_ack, go to DONE; for a read, also register mem_rdata into RAM_data.
  - DONE: mdr_load=1 for reads only; return to IDLE.
- Latency: with zero-wait memory (mem_ack in the first BUSY cycle), request accepted at edge k gives mdr_load high in cycle k+2. This matches MIC-1 read timing.
- rd_req and wr_req together: the write executes, the read is dropped, and err is set.
- Fetch FSM (IDLE/BUSY/DONE): same structure on the imem port, independent of the data FSM. It runs concurrently with data accesses. In DONE, ROM_data = {24'b0, byte} and mbr_load=1.
- stall is combinational:
  - stall = ((rd_req|wr_req) & data_state!=IDLE) | (fetch_req & fetch_state!=IDLE).
  - Requests are accepted only in IDLE with stall=0.
- A request held high across IDLE re-entry is accepted again. The datapath must deassert a request once it is no longer stalled.
- RAM_data and ROM_data hold their value until the next completed read or fetch.
- Writes never modify RAM_data.
- mem_req and imem_req drop in the cycle after ack is sampled. An ack while not BUSY is ignored.
- Reset mid-transaction aborts immediately: req outputs go low and no load pulse is issued.
- err clears only on reset.

Optional Feature:
- MEM_TIMEOUT_EN
- Defined:
  - Each BUSY state counts cycles. When TIMEOUT_CYCLES elapse without ack, the FSM goes to DONE.
  - RAM_data becomes 32'hDEADBEEF (reads), or ROM_data becomes 32'h000000FF (fetch); err is set.
  - The counter resets on every BUSY entry.
- Undefined: BUSY waits indefinitely and no counter logic exists.

Test Plan:
- Reset, then read with MAR=0x10 and mem_ack in the first BUSY cycle with mem_rdata=0xCAFEBABE → mem_addr=0x40, mem_we=0, mdr_load in cycle k+2, RAM_data=0xCAFEBABE.
- Write with MAR=0x3, MDR=0x12345678, ack after 3 cycles → mem_we=1, mem_addr=0xC, mem_wdata=0x12345678; no mdr_load; RAM_data unchanged.
- Fetch at PC=0x7 with imem_rdata=0xA5, concurrent with a read held 4 cycles → imem_addr=7, ROM_data=0x000000A5, mbr_load pulses independently of mdr_load.
- Second rd_req while data BUSY → stall=1 until DONE; the request is then accepted and exactly one additional mem_req transaction occurs.
- rd_req and wr_req in the same cycle → one write transaction, err=1, no mdr_load; reset low mid-BUSY → mem_req=0 and err=0 asynchronously.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read with no ack → DONE after 4 BUSY cycles, RAM_data=0xDEADBEEF, err=1.
